// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/half/word loads and stores onto a word-wide memory, using read-modify-write for sub-word stores.
module mem_access_ctrl #(
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  input  logic [31:0] inAddr,
  input  logic [31:0] inWriteData,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inSize,
  input  logic        inUnsigned,
  output logic        outStall,
  output logic [31:0] outMemAddress,
  output logic [31:0] outMemWriteData,
  output logic        outMemRead,
  output logic        outMemWrite,
  input  logic [31:0] inMemReadData,
  output logic [31:0] outLoadData,
  output logic        outLoadValid,
  output logic        outMisaligned
);
  typedef enum logic [2:0] {IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR} state_t;
  state_t      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [1:0]  lane_q, lane_d, size_q, size_d;
  logic        uns_q, uns_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic        load_valid_q, load_valid_d, mis_q, mis_d;
  logic        req, aligned, legal, accept;
  logic [4:0]  sh;
  logic [31:0] mask, merged, lane_val, ext;
  logic        unused_addr;
  assign unused_addr = ^inAddr[31:AW+2];
  always_comb begin
    req      = inValid & (inMemRead | inMemWrite);
    aligned  = (inSize == 2'b00) | (inSize == 2'b01 & ~inAddr[0]) | (inSize == 2'b10 & inAddr[1:0] == 2'b00);
    legal    = (inMemRead ^ inMemWrite) & aligned;
    accept   = (state_q == IDLE) & req & legal;
    sh       = {lane_q, 3'b000};
    mask     = size_q == 2'b00 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    // wdata_q still holds the right-aligned store data while in RMW_RD
    merged   = (inMemReadData & ~(mask << sh)) | ((wdata_q & mask) << sh);
    lane_val = inMemReadData >> sh;
    ext      = size_q == 2'b00 ? {{24{~uns_q & lane_val[7]}}, lane_val[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & lane_val[15]}}, lane_val[15:0]} : lane_val;
    state_d  = accept ? (inMemRead ? LD_RD : inSize == 2'b10 ? ST_WR : RMW_RD) :
               state_q == RMW_RD ? RMW_WR : IDLE;
    mem_rd_d     = state_d == LD_RD || state_d == RMW_RD;
    mem_wr_d     = state_d == ST_WR || state_d == RMW_WR;
    mem_addr_d   = accept ? {{(32-AW){1'b0}}, inAddr[AW+1:2]} : mem_addr_q;
    wdata_d      = accept ? inWriteData : state_q == RMW_RD ? merged : wdata_q;
    lane_d       = accept ? inAddr[1:0] : lane_q;
    size_d       = accept ? inSize : size_q;
    uns_d        = accept ? inUnsigned : uns_q;
    load_data_d  = state_q == LD_RD ? ext : load_data_q;
    load_valid_d = state_q == LD_RD;
    mis_d        = (state_q == IDLE) & req & ~legal;
    outStall     = accept | (state_q == RMW_RD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      load_valid_q <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      load_valid_q <= load_valid_d;
      mis_q        <= mis_d;
    end
  end
  assign outMemAddress   = mem_addr_q;
  assign outMemWriteData = wdata_q;
  assign outMemRead      = mem_rd_q;
  assign outMemWrite     = mem_wr_q;
  assign outLoadData     = load_data_q;
  assign outLoadValid    = load_valid_q;
  assign outMisaligned   = mis_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed load/store/RMW/misalignment/reset sequence against a behavioural word memory.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inMemRead, inMemWrite, inUnsigned;
  logic [31:0] inAddr, inWriteData, inMemReadData;
  logic [1:0]  inSize;
  logic        outStall, outMemRead, outMemWrite, outLoadValid, outMisaligned;
  logic [31:0] outMemAddress, outMemWriteData, outLoadData;
  logic [31:0] mem [32];
  int          wr_cnt = 0;
  int          passed = 0;
  int          total = 0;
  int          w0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inAddr(inAddr), .inWriteData(inWriteData),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inSize(inSize), .inUnsigned(inUnsigned),
    .outStall(outStall), .outMemAddress(outMemAddress), .outMemWriteData(outMemWriteData),
    .outMemRead(outMemRead), .outMemWrite(outMemWrite), .inMemReadData(inMemReadData),
    .outLoadData(outLoadData), .outLoadValid(outLoadValid), .outMisaligned(outMisaligned)
  );
  assign inMemReadData = mem[outMemAddress[4:0]];
  always @(posedge clk) begin
    if (outMemWrite) begin
      mem[outMemAddress[4:0]] <= outMemWriteData;
      wr_cnt <= wr_cnt + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    inValid = 1'b1; inMemRead = rd; inMemWrite = wr; inSize = sz; inUnsigned = uns;
    inAddr = a; inWriteData = d;
  endtask
  task automatic release_in();
    inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0; inSize = 2'b00; inUnsigned = 1'b0;
    inAddr = 32'h0; inWriteData = 32'h0;
  endtask
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    #1 chk({tag, "_stall_c1"}, {31'b0, outStall}, 32'h1);
    tick();
    release_in();
    #1 chk({tag, "_rd_c2"}, {31'b0, outMemRead}, 32'h1);
    chk({tag, "_stall_c2"}, {31'b0, outStall}, 32'h0);
    chk({tag, "_idx"}, outMemAddress, {27'b0, a[6:2]});
    tick();
    chk({tag, "_valid_c3"}, {31'b0, outLoadValid}, 32'h1);
    chk({tag, "_data"}, outLoadData, exp);
  endtask
  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic rmw, input logic [31:0] exp_word);
    w0 = wr_cnt;
    drive(1'b0, 1'b1, sz, 1'b0, a, d);
    #1 chk({tag, "_stall_c1"}, {31'b0, outStall}, 32'h1);
    tick();
    release_in();
    #1;
    if (rmw) begin
      chk({tag, "_stall_c2"}, {31'b0, outStall}, 32'h1);
      chk({tag, "_rmw_rd"}, {31'b0, outMemRead}, 32'h1);
      tick();
    end
    chk({tag, "_wr"}, {31'b0, outMemWrite}, 32'h1);
    chk({tag, "_stall_last"}, {31'b0, outStall}, 32'h0);
    chk({tag, "_idx"}, outMemAddress, {27'b0, a[6:2]});
    chk({tag, "_wdata"}, outMemWriteData, exp_word);
    tick();
    chk({tag, "_wr_done"}, {31'b0, outMemWrite}, 32'h0);
    chk({tag, "_one_write"}, wr_cnt - w0, 32'h1);
    chk({tag, "_mem"}, mem[a[6:2]], exp_word);
  endtask
  task automatic do_bad(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a);
    w0 = wr_cnt;
    drive(rd, wr, sz, 1'b0, a, 32'hDEAD_BEEF);
    #1 chk({tag, "_stall"}, {31'b0, outStall}, 32'h0);
    tick();
    release_in();
    #1 chk({tag, "_mis"}, {31'b0, outMisaligned}, 32'h1);
    chk({tag, "_strobes"}, {30'b0, outMemRead, outMemWrite}, 32'h0);
    chk({tag, "_stall2"}, {31'b0, outStall}, 32'h0);
    tick();
    chk({tag, "_mis_done"}, {31'b0, outMisaligned}, 32'h0);
    chk({tag, "_no_write"}, wr_cnt - w0, 32'h0);
  endtask
  initial begin
    rst_n = 1'b0;
    release_in();
    tick();
    tick();
    chk("rst_stall", {31'b0, outStall}, 32'h0);
    chk("rst_strobes", {30'b0, outMemRead, outMemWrite}, 32'h0);
    chk("rst_addr", outMemAddress, 32'h0);
    chk("rst_wdata", outMemWriteData, 32'h0);
    chk("rst_load", {outLoadData[30:0], outLoadValid}, 32'h0);
    chk("rst_mis", {31'b0, outMisaligned}, 32'h0);
    rst_n = 1'b1;
    tick();
    do_store("sw08", 2'b10, 32'h08, 32'h1122_3344, 1'b0, 32'h1122_3344);
    do_load("lw08", 2'b10, 1'b0, 32'h08, 32'h1122_3344);
    do_load("lb09", 2'b00, 1'b0, 32'h09, 32'h0000_0033);
    do_load("lb0B", 2'b00, 1'b0, 32'h0B, 32'h0000_0011);
    do_load("lbu08", 2'b00, 1'b1, 32'h08, 32'h0000_0044);
    do_store("sb0A", 2'b00, 32'h0A, 32'h0000_00AB, 1'b1, 32'h11AB_3344);
    do_load("lb0A", 2'b00, 1'b0, 32'h0A, 32'hFFFF_FFAB);
    do_store("sh08", 2'b01, 32'h08, 32'h0000_FF80, 1'b1, 32'h11AB_FF80);
    do_load("lh08", 2'b01, 1'b0, 32'h08, 32'hFFFF_FF80);
    do_load("lhu08", 2'b01, 1'b1, 32'h08, 32'h0000_FF80);
    do_load("lhu0A", 2'b01, 1'b1, 32'h0A, 32'h0000_11AB);
    do_load("lw88_wrap", 2'b10, 1'b0, 32'h88, 32'h11AB_FF80);
    do_bad("lw06", 1'b1, 1'b0, 2'b10, 32'h06);
    do_bad("sh05", 1'b0, 1'b1, 2'b01, 32'h05);
    do_bad("size11", 1'b1, 1'b0, 2'b11, 32'h08);
    do_bad("both", 1'b1, 1'b1, 2'b10, 32'h08);
    w0 = wr_cnt;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    #1 chk("nop_stall", {31'b0, outStall}, 32'h0);
    tick();
    release_in();
    #1 chk("nop_quiet", {29'b0, outMemRead, outMemWrite, outMisaligned}, 32'h0);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h08, 32'h0000_0055);
    tick();
    release_in();
    #1 chk("abort_in_rmw_rd", {31'b0, outMemRead}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("abort_stall", {31'b0, outStall}, 32'h0);
    chk("abort_strobes", {30'b0, outMemRead, outMemWrite}, 32'h0);
    chk("abort_addr", outMemAddress, 32'h0);
    chk("abort_wdata", outMemWriteData, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("abort_no_write", wr_cnt - w0, 32'h0);
    chk("abort_mem", mem[2], 32'h11AB_FF80);
    do_load("lw_after_abort", 2'b10, 1'b0, 32'h08, 32'h11AB_FF80);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
